evr_link_supervisor: RTL

Link supervisor and reset sequencer for the EVR receive path. It watches the 16-bit GTX receive word (data byte plus event byte) and the transceiver ready status. It drives the GTX receive reset and produces `LocalReset`, which holds the timestamp decoder and all event-receiver trigger channels in reset until the link is proven good. It also re-sequences the link automatically on loss of comma, excessive code errors or loss of transceiver ready, and exports link status and error counters.

---
 rtl/evr_link_supervisor.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/evr_link_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : evr_link_supervisor
//  Purpose  : Link supervisor and reset sequencer for the EVR receive path.
//             It drives the GTX receive reset, waits for the transceiver to
//             report ready, and requires a run of clean commas before it
//             releases LocalReset to the timestamp decoder and trigger
//             channels. It re-sequences the link when commas stop, when
//             gtReady drops, or when too many code errors fall in one
//             error window. It also exports link status and error counters.
//
//  Ports    :
//    Clock        in   GTX rxusrclk2; the only clock
//    Reset        in   asynchronous, active-high
//    rxData       in   [15:8] data byte, [7:0] event byte
//    rxCharIsK    in   [1] K flag of data byte, [0] K flag of event byte
//    rxCodeErr    in   disparity / not-in-table error for this word
//    gtReady      in   GTX receive reset done
//    gtRxReset    out  reset request to the GTX receiver
//    LocalReset   out  reset to decoders and trigger channels
//    linkUp       out  high only while LOCKED
//    state        out  HOLD=0, WAIT_GT=1, ACQUIRE=2, LOCKED=3
//    errCount     out  saturating count of code errors seen while LOCKED
//    relockCount  out  saturating count of LOCKED -> HOLD transitions
//
//  Revision : 1.0  initial release
// ============================================================================
module evr_link_supervisor #(
   parameter int RESET_HOLD    = 256,
   parameter int GT_TIMEOUT    = 65536,
   parameter int COMMA_TIMEOUT = 1024,
   parameter int LOCK_COMMAS   = 16,
   parameter int ERR_LIMIT     = 8,
   parameter int ERR_WINDOW    = 4096
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] rxData,
   input  logic [1:0]  rxCharIsK,
   input  logic        rxCodeErr,
   input  logic        gtReady,
   output logic        gtRxReset,
   output logic        LocalReset,
   output logic        linkUp,
   output logic [1:0]  state,
   output logic [15:0] errCount,
   output logic [7:0]  relockCount
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] ST_HOLD    = 2'd0;
   localparam logic [1:0] ST_WAIT_GT = 2'd1;
   localparam logic [1:0] ST_ACQUIRE = 2'd2;
   localparam logic [1:0] ST_LOCKED  = 2'd3;

   localparam logic [7:0] K28_5 = 8'hBC;

   // ------------------------------------------------------------------------
   // Counter widths and terminal values
   // ------------------------------------------------------------------------
   localparam int HOLD_W  = $clog2(RESET_HOLD + 1);
   localparam int GT_W    = $clog2(GT_TIMEOUT + 1);
   // The gap counter must be able to hold COMMA_TIMEOUT+1 without wrapping.
   localparam int GAP_W   = $clog2(COMMA_TIMEOUT + 2);
   localparam int COMMA_W = $clog2(LOCK_COMMAS + 1);
   localparam int WIN_W   = $clog2(ERR_WINDOW + 1);
   localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
   localparam logic [GT_W-1:0]    GT_LAST    = GT_W'(GT_TIMEOUT - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(COMMA_TIMEOUT);
   localparam logic [COMMA_W-1:0] LOCK_LAST  = COMMA_W'(LOCK_COMMAS - 1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(ERR_WINDOW - 1);
   localparam logic [WERR_W-1:0]  ERR_REACH  = WERR_W'(ERR_LIMIT);
   localparam logic [WERR_W-1:0]  WERR_ONE   = WERR_W'(1);

   // ------------------------------------------------------------------------
   // Registers and next-state values
   // ------------------------------------------------------------------------
   logic [1:0]         state_nxt;
   logic [HOLD_W-1:0]  hold_cnt,   hold_nxt;
   logic [GT_W-1:0]    gt_cnt,     gt_nxt;
   logic [GAP_W-1:0]   gap_cnt,    gap_nxt;
   logic [COMMA_W-1:0] comma_cnt,  comma_nxt;
   logic [WIN_W-1:0]   win_cnt,    win_cnt_nxt;
   logic [WERR_W-1:0]  win_err,    win_err_nxt;
   logic               relock_evt;

   // ------------------------------------------------------------------------
   // Word classification
   // ------------------------------------------------------------------------
   logic is_comma;
   logic code_err;
   logic gap_expired;
   logic win_wrap;
   logic [WERR_W-1:0] win_err_upd;
   logic err_limit_hit;

   // The event byte content is irrelevant here; only its K flag matters.
   logic unused_event_byte;
   assign unused_event_byte = ^rxData[7:0];

   assign is_comma = rxCharIsK[1] && (rxData[15:8] == K28_5);

   // A K character in the event byte, or any K in the data byte that is not
   // K28.5, is treated as a code error. Coincident error sources count once.
   assign code_err = rxCodeErr
                   || rxCharIsK[0]
                   || (rxCharIsK[1] && (rxData[15:8] != K28_5));

   // The gap counter would step to COMMA_TIMEOUT+1 on this edge.
   assign gap_expired = !is_comma && (gap_cnt == GAP_LAST);

   assign win_wrap = (win_cnt == WIN_LAST);

   // An error in the wrap cycle belongs to the new window, so the wrap
   // restarts the count at the current cycle's error rather than at zero.
   always_comb begin
      win_err_upd = win_err;
      if (win_wrap) begin
         win_err_upd = code_err ? WERR_ONE : '0;
      end else if (code_err) begin
         win_err_upd = win_err + WERR_ONE;
      end
   end

   assign err_limit_hit = code_err && (win_err_upd == ERR_REACH);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      gt_nxt      = gt_cnt;
      gap_nxt     = gap_cnt;
      comma_nxt   = comma_cnt;
      win_cnt_nxt = win_cnt;
      win_err_nxt = win_err;
      relock_evt  = 1'b0;

      case (state)
         ST_HOLD: begin
            // Everything downstream of HOLD starts from a clean slate.
            gt_nxt      = '0;
            gap_nxt     = '0;
            comma_nxt   = '0;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
            if (hold_cnt == HOLD_LAST) begin
               hold_nxt  = '0;
               state_nxt = ST_WAIT_GT;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end

         ST_WAIT_GT: begin
            if (gtReady) begin
               state_nxt = ST_ACQUIRE;
               gt_nxt    = '0;
               gap_nxt   = '0;
               comma_nxt = '0;
            end else if (gt_cnt == GT_LAST) begin
               state_nxt = ST_HOLD;
               gt_nxt    = '0;
               hold_nxt  = '0;
            end else begin
               gt_nxt = gt_cnt + 1'b1;
            end
         end

         ST_ACQUIRE: begin
            gap_nxt = is_comma ? '0 : gap_cnt + 1'b1;
            if (!gtReady || gap_expired) begin
               state_nxt = ST_HOLD;
               hold_nxt  = '0;
               gap_nxt   = '0;
               comma_nxt = '0;
            end else if (code_err) begin
               // Lock requires an unbroken run of clean commas.
               comma_nxt = '0;
            end else if (is_comma) begin
               if (comma_cnt == LOCK_LAST) begin
                  state_nxt   = ST_LOCKED;
                  comma_nxt   = '0;
                  win_cnt_nxt = '0;
                  win_err_nxt = '0;
               end else begin
                  comma_nxt = comma_cnt + 1'b1;
               end
            end
         end

         ST_LOCKED: begin
            gap_nxt     = is_comma ? '0 : gap_cnt + 1'b1;
            win_cnt_nxt = win_wrap ? '0 : win_cnt + 1'b1;
            win_err_nxt = win_err_upd;
            // All three faults share one exit so a coincident pair still
            // produces a single relock.
            if (!gtReady || gap_expired || err_limit_hit) begin
               state_nxt   = ST_HOLD;
               relock_evt  = 1'b1;
               hold_nxt    = '0;
               gap_nxt     = '0;
               win_cnt_nxt = '0;
               win_err_nxt = '0;
            end
         end

         default: begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers. Outputs are decoded from the next state so that they change
   // on the same edge as the state itself.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= ST_HOLD;
         hold_cnt    <= '0;
         gt_cnt      <= '0;
         gap_cnt     <= '0;
         comma_cnt   <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         gtRxReset   <= 1'b1;
         LocalReset  <= 1'b1;
         linkUp      <= 1'b0;
         errCount    <= '0;
         relockCount <= '0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         gt_cnt     <= gt_nxt;
         gap_cnt    <= gap_nxt;
         comma_cnt  <= comma_nxt;
         win_cnt    <= win_cnt_nxt;
         win_err    <= win_err_nxt;
         gtRxReset  <= (state_nxt == ST_HOLD);
         LocalReset <= (state_nxt != ST_LOCKED);
         linkUp     <= (state_nxt == ST_LOCKED);

         // Errors are counted whenever they are sampled in LOCKED, including
         // the cycle that causes the exit.
         if ((state == ST_LOCKED) && code_err && (errCount != '1)) begin
            errCount <= errCount + 1'b1;
         end
         if (relock_evt && (relockCount != '1)) begin
            relockCount <= relockCount + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
